// File: rtl/int_context_ctrl_if.sv
// Fetch/interrupt handshake bundle between the sequencer (slave) and its
// fetch/decode/CC-bank neighbours (master).
interface int_context_ctrl_if #(
  parameter int VEC_W = 16
);
  logic             FETCH;
  logic             INTEN;
  logic             INT0_REQ;
  logic             INT1_REQ;
  logic             RETI;
  logic [1:0]       CC_REGX;
  logic             CCL_ENRX;
  logic             CCL_EN0X;
  logic             CCL_EN1X;
  logic             INT_TAKE;
  logic [VEC_W-1:0] INT_VECTOR;
  logic             INT0_ACK;
  logic             INT1_ACK;
  logic [1:0]       INT_LEVEL;

  modport master (
    output FETCH, INTEN, INT0_REQ, INT1_REQ, RETI,
    input  CC_REGX, CCL_ENRX, CCL_EN0X, CCL_EN1X,
    input  INT_TAKE, INT_VECTOR, INT0_ACK, INT1_ACK, INT_LEVEL
  );

  modport slave (
    input  FETCH, INTEN, INT0_REQ, INT1_REQ, RETI,
    output CC_REGX, CCL_ENRX, CCL_EN0X, CCL_EN1X,
    output INT_TAKE, INT_VECTOR, INT0_ACK, INT1_ACK, INT_LEVEL
  );
endinterface

// File: rtl/int_context_ctrl.sv
// Two-level interrupt context sequencer driving the CC bank select/load enables.
// Optional: INT_EDGE_DETECT_EN makes pending requests edge-latched instead of level.
module int_context_ctrl #(
  parameter int               VEC_W = 16,
  parameter logic [VEC_W-1:0] VEC0  = 16'h0008,
  parameter logic [VEC_W-1:0] VEC1  = 16'h0010
) (
  input logic               CLK,
  input logic               RESET,
  int_context_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_I0,
    S_I1,
    S_I1N
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_p0;
  logic       w_p1;
  logic       w_take0;
  logic       w_take1;
  logic       w_elig;
  logic       w_reti;
  logic [1:0] w_lvl;

`ifdef INT_EDGE_DETECT_EN
  logic r_prev0;
  logic r_prev1;
  logic r_p0;
  logic r_p1;

  // A fresh edge counts in the cycle it arrives, so a take can consume it immediately.
  assign w_p0 = r_p0 | (bus.INT0_REQ & ~r_prev0);
  assign w_p1 = r_p1 | (bus.INT1_REQ & ~r_prev1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_prev0 <= 1'b0;
      r_prev1 <= 1'b0;
      r_p0    <= 1'b0;
      r_p1    <= 1'b0;
    end else begin
      r_prev0 <= bus.INT0_REQ;
      r_prev1 <= bus.INT1_REQ;
      r_p0    <= w_p0 & ~w_take0;
      r_p1    <= w_p1 & ~w_take1;
    end
  end
`else
  assign w_p0 = bus.INT0_REQ;
  assign w_p1 = bus.INT1_REQ;
`endif

  assign w_reti = bus.FETCH & bus.RETI;
  assign w_elig = bus.FETCH & bus.INTEN & ~bus.RETI;

  always_comb begin
    w_take0 = 1'b0;
    w_take1 = 1'b0;
    w_next  = r_state;
    if (w_reti) begin
      case (r_state)
        S_I0:    w_next = S_RUN;
        S_I1:    w_next = S_RUN;
        S_I1N:   w_next = S_I0;
        default: w_next = S_RUN;
      endcase
    end else if (w_elig) begin
      case (r_state)
        S_RUN: begin
          if (w_p1) begin
            w_take1 = 1'b1;
            w_next  = S_I1;
          end else if (w_p0) begin
            w_take0 = 1'b1;
            w_next  = S_I0;
          end
        end
        S_I0: begin
          if (w_p1) begin
            w_take1 = 1'b1;
            w_next  = S_I1N;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    case (w_next)
      S_RUN:   w_lvl = 2'b00;
      S_I0:    w_lvl = 2'b01;
      default: w_lvl = 2'b10;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state        <= S_RUN;
      bus.CC_REGX    <= 2'b00;
      bus.INT_LEVEL  <= 2'b00;
      bus.CCL_ENRX   <= 1'b1;
      bus.CCL_EN0X   <= 1'b0;
      bus.CCL_EN1X   <= 1'b0;
      bus.INT_TAKE   <= 1'b0;
      bus.INT0_ACK   <= 1'b0;
      bus.INT1_ACK   <= 1'b0;
      bus.INT_VECTOR <= '0;
    end else begin
      r_state       <= w_next;
      bus.CC_REGX   <= w_lvl;
      bus.INT_LEVEL <= w_lvl;
      bus.CCL_ENRX  <= (w_lvl == 2'b00);
      bus.CCL_EN0X  <= (w_lvl == 2'b01);
      bus.CCL_EN1X  <= (w_lvl == 2'b10);
      bus.INT_TAKE  <= w_take0 | w_take1;
      bus.INT0_ACK  <= w_take0;
      bus.INT1_ACK  <= w_take1;
      if (w_take1)
        bus.INT_VECTOR <= VEC1;
      else if (w_take0)
        bus.INT_VECTOR <= VEC0;
    end
  end

endmodule

// File: tb/tb_int_context_ctrl.sv
// Self-checking bench for int_context_ctrl: directed scenarios plus random
// stimulus against a context-stack reference model.
module tb_int_context_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  int_context_ctrl_if #(.VEC_W(16)) bus();

  int_context_ctrl #(.VEC_W(16), .VEC0(16'h0008), .VEC1(16'h0010)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a stack of active interrupt levels (0 or 1), empty = RUN.
  int          stk[$];
  logic        m_take, m_ack0, m_ack1;
  logic [15:0] m_vec;
  logic [1:0]  m_lvl;
  logic        mp0, mp1, mprev0, mprev1;

  function automatic logic [2:0] ens_of(input logic [1:0] l);
    return (l == 2'd0) ? 3'b100 : (l == 2'd1) ? 3'b010 : 3'b001;
  endfunction

  task automatic model_reset();
    stk.delete();
    m_take = 0; m_ack0 = 0; m_ack1 = 0;
    m_vec = 16'h0; m_lvl = 2'd0;
    mp0 = 0; mp1 = 0; mprev0 = 0; mprev1 = 0;
  endtask

  task automatic model_step();
    logic p0, p1, t0, t1;
    int   top;
`ifdef INT_EDGE_DETECT_EN
    p0 = mp0 | (bus.INT0_REQ & ~mprev0);
    p1 = mp1 | (bus.INT1_REQ & ~mprev1);
`else
    p0 = bus.INT0_REQ;
    p1 = bus.INT1_REQ;
`endif
    t0 = 0; t1 = 0;
    top = (stk.size() == 0) ? -1 : stk[$];
    if (bus.FETCH && bus.RETI) begin
      if (stk.size() != 0) void'(stk.pop_back());
    end else if (bus.FETCH && bus.INTEN) begin
      if (top != 1 && p1) begin t1 = 1; stk.push_back(1); end
      else if (stk.size() == 0 && p0) begin t0 = 1; stk.push_back(0); end
    end
    mp0 = p0 & ~t0; mp1 = p1 & ~t1;
    mprev0 = bus.INT0_REQ; mprev1 = bus.INT1_REQ;
    m_take = t0 | t1; m_ack0 = t0; m_ack1 = t1;
    if (t1) m_vec = 16'h0010; else if (t0) m_vec = 16'h0008;
    m_lvl = (stk.size() == 0) ? 2'd0 : (stk[$] == 0) ? 2'd1 : 2'd2;
  endtask

  task automatic drive(input logic f, input logic en, input logic q0, input logic q1, input logic r);
    bus.FETCH = f; bus.INTEN = en; bus.INT0_REQ = q0; bus.INT1_REQ = q1; bus.RETI = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    n_cmp++; if (bus.CC_REGX !== 2'b00) begin n_bad++; $display("FAIL reset_cc got %b want 00", bus.CC_REGX); end
    n_cmp++; if ({bus.CCL_ENRX, bus.CCL_EN0X, bus.CCL_EN1X} !== 3'b100) begin n_bad++; $display("FAIL reset_en got %b want 100", {bus.CCL_ENRX, bus.CCL_EN0X, bus.CCL_EN1X}); end
    n_cmp++; if ({bus.INT_TAKE, bus.INT0_ACK, bus.INT1_ACK} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {bus.INT_TAKE, bus.INT0_ACK, bus.INT1_ACK}); end
    n_cmp++; if (bus.INT_VECTOR !== 16'h0) begin n_bad++; $display("FAIL reset_vec got %h want 0000", bus.INT_VECTOR); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({bus.CC_REGX, bus.CCL_ENRX, bus.INT_TAKE} !== 4'b0010) begin n_bad++; $display("FAIL idle_fetch got cc=%b enr=%b take=%b want 00/1/0", bus.CC_REGX, bus.CCL_ENRX, bus.INT_TAKE); end
    end
  endtask

  task automatic test_int0();
    drive(1, 1, 1, 0, 0);
    tick();
    n_cmp++; if ({bus.INT_TAKE, bus.INT0_ACK, bus.INT1_ACK} !== 3'b110) begin n_bad++; $display("FAIL int0_pulses got %b want 110", {bus.INT_TAKE, bus.INT0_ACK, bus.INT1_ACK}); end
    n_cmp++; if (bus.INT_VECTOR !== 16'h0008) begin n_bad++; $display("FAIL int0_vec got %h want 0008", bus.INT_VECTOR); end
    n_cmp++; if ({bus.CC_REGX, bus.CCL_ENRX, bus.CCL_EN0X, bus.CCL_EN1X} !== 5'b01010) begin n_bad++; $display("FAIL int0_ctx got cc=%b en=%b want 01/010", bus.CC_REGX, {bus.CCL_ENRX, bus.CCL_EN0X, bus.CCL_EN1X}); end
    drive(0, 1, 0, 0, 0);
    tick();
    n_cmp++; if ({bus.INT_TAKE, bus.INT0_ACK, bus.INT_VECTOR, bus.CC_REGX} !== {2'b00, 16'h0008, 2'b01}) begin n_bad++; $display("FAIL int0_hold got take=%b ack=%b vec=%h cc=%b want 0/0/0008/01", bus.INT_TAKE, bus.INT0_ACK, bus.INT_VECTOR, bus.CC_REGX); end
    drive(1, 1, 0, 0, 1);
    tick();
    n_cmp++; if ({bus.CC_REGX, bus.INT_LEVEL} !== 4'b0000) begin n_bad++; $display("FAIL int0_reti got cc=%b lvl=%b want 00", bus.CC_REGX, bus.INT_LEVEL); end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 1, 0);
    tick();
    n_cmp++; if ({bus.INT1_ACK, bus.INT0_ACK, bus.INT_VECTOR, bus.CC_REGX} !== {2'b10, 16'h0010, 2'b10}) begin n_bad++; $display("FAIL prio_take got ack1=%b ack0=%b vec=%h cc=%b want 1/0/0010/10", bus.INT1_ACK, bus.INT0_ACK, bus.INT_VECTOR, bus.CC_REGX); end
    drive(1, 1, 1, 0, 1);
    tick();
    n_cmp++; if ({bus.CC_REGX, bus.INT_TAKE} !== 3'b000) begin n_bad++; $display("FAIL prio_reti got cc=%b take=%b want 00/0", bus.CC_REGX, bus.INT_TAKE); end
    drive(1, 1, 1, 0, 0);
    tick();
    n_cmp++; if ({bus.INT0_ACK, bus.CC_REGX} !== 3'b101) begin n_bad++; $display("FAIL prio_int0_pending got ack0=%b cc=%b want 1/01", bus.INT0_ACK, bus.CC_REGX); end
    drive(1, 1, 0, 0, 1);
    tick();
  endtask

  task automatic test_nested();
    drive(1, 1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0);
    tick();
    n_cmp++; if ({bus.INT1_ACK, bus.CC_REGX, bus.CCL_EN1X} !== 4'b1101) begin n_bad++; $display("FAIL nest_take got ack1=%b cc=%b en1=%b want 1/10/1", bus.INT1_ACK, bus.CC_REGX, bus.CCL_EN1X); end
    drive(1, 1, 0, 0, 1);
    tick();
    n_cmp++; if ({bus.CC_REGX, bus.CCL_EN0X} !== 3'b011) begin n_bad++; $display("FAIL nest_reti1 got cc=%b en0=%b want 01/1", bus.CC_REGX, bus.CCL_EN0X); end
    tick();
    n_cmp++; if ({bus.CC_REGX, bus.CCL_ENRX} !== 3'b001) begin n_bad++; $display("FAIL nest_reti2 got cc=%b enr=%b want 00/1", bus.CC_REGX, bus.CCL_ENRX); end
  endtask

  task automatic test_reti_wins();
    drive(1, 1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 1, 1);
    tick();
    n_cmp++; if ({bus.CC_REGX, bus.INT_TAKE} !== 3'b000) begin n_bad++; $display("FAIL reti_wins got cc=%b take=%b want 00/0", bus.CC_REGX, bus.INT_TAKE); end
    drive(1, 1, 0, 1, 0);
    tick();
    n_cmp++; if ({bus.INT_TAKE, bus.INT1_ACK, bus.CC_REGX} !== 4'b1110) begin n_bad++; $display("FAIL reti_wins_next got take=%b ack1=%b cc=%b want 1/1/10", bus.INT_TAKE, bus.INT1_ACK, bus.CC_REGX); end
    drive(1, 1, 0, 0, 1);
    tick();
  endtask

  task automatic test_async_reset();
    int acks;
    drive(1, 1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0);
    tick();
    n_cmp++; if ({bus.INT_TAKE, bus.CC_REGX} !== 3'b110) begin n_bad++; $display("FAIL pre_reset got take=%b cc=%b want 1/10", bus.INT_TAKE, bus.CC_REGX); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.CC_REGX, bus.INT_LEVEL, bus.CCL_ENRX, bus.CCL_EN0X, bus.CCL_EN1X} !== 7'b0000100) begin n_bad++; $display("FAIL async_reset_ctx got cc=%b lvl=%b en=%b want 00/00/100", bus.CC_REGX, bus.INT_LEVEL, {bus.CCL_ENRX, bus.CCL_EN0X, bus.CCL_EN1X}); end
    n_cmp++; if ({bus.INT_TAKE, bus.INT0_ACK, bus.INT1_ACK, bus.INT_VECTOR} !== 19'h0) begin n_bad++; $display("FAIL async_reset_pulses got take=%b acks=%b vec=%h want 0/00/0000", bus.INT_TAKE, {bus.INT0_ACK, bus.INT1_ACK}, bus.INT_VECTOR); end
    drive(1, 1, 0, 0, 0);
    model_reset();
    #1 rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(bus.INT0_ACK) + int'(bus.INT1_ACK);
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL post_reset_ack got %0d want 0", acks); end
    // held INT0 request across two RETIs
    acks = 0;
    drive(1, 1, 1, 0, 0); tick(); acks += int'(bus.INT0_ACK);
    drive(1, 1, 1, 0, 1); tick(); acks += int'(bus.INT0_ACK);
    drive(1, 1, 1, 0, 0); tick(); acks += int'(bus.INT0_ACK);
    drive(1, 1, 1, 0, 1); tick(); acks += int'(bus.INT0_ACK);
    drive(1, 1, 1, 0, 0); tick(); acks += int'(bus.INT0_ACK);
`ifdef INT_EDGE_DETECT_EN
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL held_req_acks got %0d want 1", acks); end
`else
    n_cmp++; if (acks !== 3) begin n_bad++; $display("FAIL held_req_acks got %0d want 3", acks); end
`endif
    drive(1, 1, 0, 0, 1);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) != 0),
            logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 3) == 0));
      tick();
      n_cmp++; if ({bus.CC_REGX, bus.INT_LEVEL} !== {m_lvl, m_lvl}) begin n_bad++; $display("FAIL rnd_level cyc %0d got cc=%b lvl=%b want %b", i, bus.CC_REGX, bus.INT_LEVEL, m_lvl); end
      n_cmp++; if ({bus.CCL_ENRX, bus.CCL_EN0X, bus.CCL_EN1X} !== ens_of(m_lvl)) begin n_bad++; $display("FAIL rnd_en cyc %0d got %b want %b", i, {bus.CCL_ENRX, bus.CCL_EN0X, bus.CCL_EN1X}, ens_of(m_lvl)); end
      n_cmp++; if ({bus.INT_TAKE, bus.INT0_ACK, bus.INT1_ACK} !== {m_take, m_ack0, m_ack1}) begin n_bad++; $display("FAIL rnd_pulses cyc %0d got %b want %b", i, {bus.INT_TAKE, bus.INT0_ACK, bus.INT1_ACK}, {m_take, m_ack0, m_ack1}); end
      n_cmp++; if (bus.INT_VECTOR !== m_vec) begin n_bad++; $display("FAIL rnd_vec cyc %0d got %h want %h", i, bus.INT_VECTOR, m_vec); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_int0();
    test_priority();
    test_nested();
    test_reti_wins();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
